// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction fetch front end.
package risc_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      REQ,
      FULL,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding fetched words with their PC; flush beats push and pop.
module fetch_fifo
   import risc_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: storage carries no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Zero the head while empty so stale words never reach the consumer.
   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, memory read handshake, redirect/flush, instruction buffer.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect target halts fetch).
module instr_fetch_unit
   import risc_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [XLEN-1:0]   mem_rd_addr,
   output logic              mem_rd_addr_valid,
   input  logic [XLEN-1:0]   mem_rd_data,
   input  logic              mem_rd_ack,
   output logic [XLEN-1:0]   instr,
   output logic [XLEN-1:0]   instr_pc,
   output logic              instr_valid,
   input  logic              instr_ack,
   input  logic [XLEN-1:0]   pc_branch_data,
   input  logic              pc_branch_data_valid,
   output logic              pc_branch_data_ack,
   output logic              fetch_misalign
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t     state;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_inc;
   logic [XLEN-1:0]  pc_next;
   logic [XLEN-1:0]  branch_target;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             ack_fire;
   logic             wait_ack;
   logic             push;
   logic             pop;
   logic             flush;
   logic             space_next;
   logic             halted;
   logic             halt_next;

   assign ack_fire      = mem_rd_addr_valid & mem_rd_ack;
   assign wait_ack      = mem_rd_addr_valid & ~mem_rd_ack;
   assign flush         = pc_branch_data_valid;
   assign push          = ack_fire & (state == REQ) & ~flush;
   assign pop           = instr_valid & instr_ack;
   assign pc_inc        = pc + XLEN'(INSTR_BYTES);
   assign pc_next       = push ? pc_inc : pc;
   assign branch_target = {pc_branch_data[XLEN-1:2], 2'b00};
   assign count_next    = count + CW'(push) - CW'(pop);
   assign space_next    = count_next < DEPTH_C;
   assign push_entry    = '{instr: mem_rd_data, pc: pc};

`ifdef IFU_MISALIGN_CHECK_EN
   logic misalign_q;

   assign halt_next = misalign_q | (pc_branch_data_valid & (pc_branch_data[1:0] != 2'b00));

   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= halt_next;
   end

   assign halted         = misalign_q;
   assign fetch_misalign = misalign_q;
`else
   logic unused_low_bits;

   assign unused_low_bits = ^pc_branch_data[1:0];
   assign halted          = 1'b0;
   assign halt_next       = 1'b0;
   assign fetch_misalign  = 1'b0;
`endif

   // NOTE: all state and registered outputs update with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= REQ;
         pc                 <= RESET_PC;
         mem_rd_addr        <= RESET_PC;
         mem_rd_addr_valid  <= 1'b0;
         pc_branch_data_ack <= 1'b0;
      end else begin
         pc_branch_data_ack <= pc_branch_data_valid;
         if (pc_branch_data_valid) begin
            pc <= branch_target;
            // Memory cannot cancel: keep the live request on the bus and drop its word later.
            if (wait_ack) begin
               state <= DRAIN;
            end else if (halt_next) begin
               state             <= FULL;
               mem_rd_addr_valid <= 1'b0;
            end else begin
               state             <= REQ;
               mem_rd_addr_valid <= 1'b1;
               mem_rd_addr       <= branch_target;
            end
         end else begin
            if (push) pc <= pc_inc;
            unique case (state)
               REQ, FULL: begin
                  if (!wait_ack) begin
                     if (!halted && space_next) begin
                        state             <= REQ;
                        mem_rd_addr_valid <= 1'b1;
                        mem_rd_addr       <= pc_next;
                     end else begin
                        state             <= FULL;
                        mem_rd_addr_valid <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (ack_fire) begin
                     state             <= halted ? FULL : REQ;
                     mem_rd_addr_valid <= ~halted;
                     mem_rd_addr       <= pc;
                  end
               end
               default: state <= REQ;
            endcase
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head)
   );

   assign instr_valid = (count != '0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit against a program-order fetch model.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_addr_valid;
   logic [31:0] mem_rd_data;
   logic        mem_rd_ack;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ack;
   logic [31:0] pc_branch_data;
   logic        pc_branch_data_valid;
   logic        pc_branch_data_ack;
   logic        fetch_misalign;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_addr_valid    (mem_rd_addr_valid),
      .mem_rd_data          (mem_rd_data),
      .mem_rd_ack           (mem_rd_ack),
      .instr                (instr),
      .instr_pc             (instr_pc),
      .instr_valid          (instr_valid),
      .instr_ack            (instr_ack),
      .pc_branch_data       (pc_branch_data),
      .pc_branch_data_valid (pc_branch_data_valid),
      .pc_branch_data_ack   (pc_branch_data_ack),
      .fetch_misalign       (fetch_misalign)
   );

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   int   vectors = 0;
   int   errors  = 0;
   exp_t exp_q[$];

   // Memory responder knobs, written by the main thread.
   int   mem_delay    = 1;
   bit   mem_random   = 0;
   bit   mem_hold     = 0;
   bit   force_ack    = 0;
   bit   spurious_ack = 0;
   int   wait_cnt     = 1;
   int   n_fetched    = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory: acks a live request after a programmable number of wait cycles.
   initial begin
      mem_rd_ack  = 1'b0;
      mem_rd_data = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_rd_ack = 1'b0;
         if (spurious_ack) begin
            mem_rd_ack = 1'b1;
         end else if (mem_rd_addr_valid && !reset) begin
            if (mem_hold)           mem_rd_ack = force_ack;
            else if (wait_cnt == 0) mem_rd_ack = 1'b1;
            else                    wait_cnt--;
         end
         if (mem_rd_ack) begin
            mem_rd_data = mem_word(mem_rd_addr);
            wait_cnt    = mem_random ? int'($urandom_range(0, 3)) : mem_delay;
         end else begin
            mem_rd_data = $urandom;
         end
      end
   end

   // Reference model (program-order fetch stream) plus monitor, sampled mid-cycle.
   logic [31:0] model_pc;
   logic [31:0] prev_addr;
   bit          stale, prev_wait, prev_redirect;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         exp_q.delete();
         model_pc      = RST_PC;
         stale         = 0;
         prev_wait     = 0;
         prev_redirect = 0;
      end else begin
         check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
         if (instr_valid && instr_ack && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr", instr, e.word);
            check("instr_pc", instr_pc, e.pc);
         end
         check("branch_ack", 32'(pc_branch_data_ack), 32'(prev_redirect));
         if (prev_wait) begin
            check("req_held", 32'(mem_rd_addr_valid), 32'd1);
            check("addr_stable", mem_rd_addr, prev_addr);
         end
         if (pc_branch_data_valid) begin
            exp_q.delete();
            model_pc = pc_branch_data & 32'hFFFF_FFFC;
            stale    = mem_rd_addr_valid && !mem_rd_ack;
         end else if (mem_rd_addr_valid && mem_rd_ack) begin
            if (stale) begin
               stale = 0;
            end else begin
               check("fetch_addr", mem_rd_addr, model_pc);
               exp_q.push_back('{word: mem_word(model_pc), pc: model_pc});
               model_pc = model_pc + 32'd4;
               n_fetched++;
            end
         end
         prev_wait     = mem_rd_addr_valid && !mem_rd_ack;
         prev_addr     = mem_rd_addr;
         prev_redirect = pc_branch_data_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      pc_branch_data       = target;
      pc_branch_data_valid = 1'b1;
   endtask

   initial begin
      int i;
      reset                = 1'b1;
      instr_ack            = 1'b0;
      pc_branch_data       = '0;
      pc_branch_data_valid = 1'b0;

      // Reset state, with a late ack straddling reset release.
      step();
      step();
      check("rst_valid", 32'(mem_rd_addr_valid), 32'd0);
      check("rst_addr", mem_rd_addr, RST_PC);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_branch_ack", 32'(pc_branch_data_ack), 32'd0);
      check("rst_misalign", 32'(fetch_misalign), 32'd0);
      reset        = 1'b0;
      spurious_ack = 1;
      step();
      spurious_ack = 0;
      check("first_req_valid", 32'(mem_rd_addr_valid), 32'd1);
      check("first_req_addr", mem_rd_addr, RST_PC);

      // Sequential fetch, memory acks every other cycle, consumer always ready.
      instr_ack = 1'b1;
      repeat (20) step();
      check("t1_fetch_count_ge4", 32'(n_fetched >= 4), 32'd1);

      // Back-pressure fills the buffer; one pop reopens fetching.
      instr_ack = 1'b0;
      mem_delay = 0;
      repeat (10) step();
      check("t2_buffered", 32'(exp_q.size()), 32'(DEPTH));
      check("t2_full_valid", 32'(mem_rd_addr_valid), 32'd0);
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      check("t2_refetch_valid", 32'(mem_rd_addr_valid), 32'd1);
      instr_ack = 1'b1;
      repeat (4) step();

      // Redirect while the 0x8 read is outstanding, ack three cycles later.
      do_reset();
      for (i = 0; i < 40 && !(mem_rd_addr_valid && mem_rd_addr == 32'h8); i++) step();
      check("t3_reach_0x8", 32'(mem_rd_addr_valid && mem_rd_addr == 32'h8), 32'd1);
      mem_hold = 1;
      redirect(32'h100);
      step();
      pc_branch_data_valid = 1'b0;
      check("t3_ack_pulse", 32'(pc_branch_data_ack), 32'd1);
      check("t3_drain_valid", 32'(mem_rd_addr_valid), 32'd1);
      check("t3_drain_addr", mem_rd_addr, 32'h8);
      check("t3_flushed", 32'(instr_valid), 32'd0);
      step();
      check("t3_ack_single", 32'(pc_branch_data_ack), 32'd0);
      step();
      force_ack = 1;
      step();
      force_ack = 0;
      mem_hold  = 0;
      check("t3_new_valid", 32'(mem_rd_addr_valid), 32'd1);
      check("t3_new_addr", mem_rd_addr, 32'h100);
      check("t3_empty", 32'(instr_valid), 32'd0);

      // Redirect coinciding with a memory ack and a consumer pop.
      instr_ack = 1'b0;
      for (i = 0; i < 40 && !(instr_valid && mem_rd_addr_valid); i++) step();
      check("t4_setup", 32'(instr_valid && mem_rd_addr_valid), 32'd1);
      mem_hold  = 1;
      force_ack = 1;
      instr_ack = 1'b1;
      redirect(32'h40);
      step();
      pc_branch_data_valid = 1'b0;
      force_ack = 0;
      mem_hold  = 0;
      instr_ack = 1'b0;
      check("t4_empty", 32'(instr_valid), 32'd0);
      check("t4_valid", 32'(mem_rd_addr_valid), 32'd1);
      check("t4_addr", mem_rd_addr, 32'h40);

      // PC wraps from the top of the address space to zero.
      instr_ack = 1'b1;
      mem_delay = 1;
      redirect(32'hFFFF_FFF8);
      step();
      pc_branch_data_valid = 1'b0;
      for (i = 0; i < 40 && !(mem_rd_addr_valid && mem_rd_addr == 32'h0); i++) step();
      check("t5_wrap_to_zero", 32'(mem_rd_addr_valid && mem_rd_addr == 32'h0), 32'd1);

      // Randomised traffic: redirects, back-pressure, memory latency, occasional reset.
      mem_random = 1;
      n_fetched  = 0;
      for (int c = 0; c < 3000; c++) begin
         instr_ack            = ($urandom_range(0, 3) != 0);
         pc_branch_data_valid = ($urandom_range(0, 9) == 0);
`ifdef IFU_MISALIGN_CHECK_EN
         pc_branch_data       = $urandom & 32'hFFFF_FFFC;
`else
         pc_branch_data       = $urandom;
`endif
         reset                = ($urandom_range(0, 299) == 0);
         step();
      end
      reset                = 1'b0;
      pc_branch_data_valid = 1'b0;
      step();
      check("rand_progress", 32'(n_fetched > 100), 32'd1);

      // Misaligned redirect from the FULL state.
      mem_random = 0;
      mem_delay  = 0;
      instr_ack  = 1'b0;
      for (i = 0; i < 40 && !(exp_q.size() == DEPTH && !mem_rd_addr_valid); i++) step();
      check("t6_full", 32'(exp_q.size() == DEPTH && !mem_rd_addr_valid), 32'd1);
      redirect(32'h102);
      step();
      pc_branch_data_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      check("t6_misalign", 32'(fetch_misalign), 32'd1);
      for (int c = 0; c < 5; c++) begin
         check("t6_halted", 32'(mem_rd_addr_valid), 32'd0);
         step();
      end
`else
      check("t6_misalign_off", 32'(fetch_misalign), 32'd0);
      check("t6_valid", 32'(mem_rd_addr_valid), 32'd1);
      check("t6_addr", mem_rd_addr, 32'h100);
`endif
      instr_ack = 1'b1;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
